uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 161 ++++++++++++++++
 tb/tb_uart_tx.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- UART serial transmitter (8N1 by default, no parity).
//
// Frame: one start bit (0), DATA_BITS data bits LSB first, one stop bit (1).
// Every bit is held for CLKS_PER_BIT clock cycles.
//
// Parameters
//   DATA_BITS     payload width per frame
//   CLKS_PER_BIT  clk_in cycles per serial bit (>= 2)
//
// Ports
//   clk_in           system clock, rising-edge active
//   n_rst            asynchronous active-low reset
//   uart_tx_en       transmit request; accepted only while uart_tx_ready=1
//   uart_tx_data_in  byte to send, captured at the handshake
//   uart_tx_ready    high exactly while the transmitter is idle
//   tx_serial_out    serial line, idle high, driven from a flop
//   tx_done          one-cycle pulse in the first idle cycle after a stop bit
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk_in,
  input  logic                 n_rst,
  input  logic                 uart_tx_en,
  input  logic [DATA_BITS-1:0] uart_tx_data_in,
  output logic                 uart_tx_ready,
  output logic                 tx_serial_out,
  output logic                 tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

  // Three-bit encoding leaves spare codes; any of them falls back to IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [BAUD_W-1:0]    r_baud;
  logic [BAUD_W-1:0]    w_baud_next;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [DATA_BITS-1:0] w_shift_dn;
  logic                 r_tx;
  logic                 w_tx_next;
  logic                 r_done;
  logic                 w_done_next;
  logic                 w_baud_end;

  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_shift_dn = r_shift >> 1;

  // State and datapath registers.
  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state and next-output logic. The line value is computed one cycle
  // ahead so that tx_serial_out comes straight from r_tx and changes exactly
  // on bit boundaries.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    w_done_next  = 1'b0;

    case (r_state)
      IDLE: begin
        w_tx_next   = 1'b1;
        w_baud_next = '0;
        w_idx_next  = '0;
        if (uart_tx_en) begin
          w_state_next = START;
          w_shift_next = uart_tx_data_in;
          w_tx_next    = 1'b0;
        end
      end

      START: begin
        if (w_baud_end) begin
          w_state_next = DATA;
          w_baud_next  = '0;
          w_idx_next   = '0;
          w_tx_next    = r_shift[0];
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end

      DATA: begin
        if (w_baud_end) begin
          w_baud_next = '0;
          if (r_idx == IDX_LAST) begin
            w_state_next = STOP;
            w_idx_next   = '0;
            w_tx_next    = 1'b1;
          end else begin
            // Shift toward bit 0 so the next data bit is always r_shift[0].
            w_idx_next   = r_idx + 1'b1;
            w_shift_next = w_shift_dn;
            w_tx_next    = w_shift_dn[0];
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end

      STOP: begin
        if (w_baud_end) begin
          w_state_next = IDLE;
          w_baud_next  = '0;
          w_done_next  = 1'b1;
          w_tx_next    = 1'b1;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end

      default: begin
        w_state_next = IDLE;
        w_baud_next  = '0;
        w_idx_next   = '0;
        w_shift_next = '0;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  assign uart_tx_ready = (r_state == IDLE);
  assign tx_serial_out = r_tx;
  assign tx_done       = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- directed self-checking bench for uart_tx
// (DATA_BITS=8, CLKS_PER_BIT=4, so one frame is 40 cycles).
// All inputs are driven and all outputs sampled 1 time unit after a rising
// clock edge. "Cycle k" of a frame is the sample taken after edge H+k-1,
// where H is the handshake edge.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  localparam int DB    = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (DB + 2) * CPB;

  logic       clk_in = 1'b0;
  logic       n_rst;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data_in;
  logic       uart_tx_ready;
  logic       tx_serial_out;
  logic       tx_done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] dec_q[$];
  int         dec_bad_period = 0;
  int         dec_bad_frame  = 0;
  int         done_count     = 0;

  uart_tx #(
    .DATA_BITS   (DB),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_in         (clk_in),
    .n_rst          (n_rst),
    .uart_tx_en     (uart_tx_en),
    .uart_tx_data_in(uart_tx_data_in),
    .uart_tx_ready  (uart_tx_ready),
    .tx_serial_out  (tx_serial_out),
    .tx_done        (tx_done)
  );

  always #5 clk_in = ~clk_in;

  // Counts tx_done pulses.
  initial begin
    forever begin
      @(posedge clk_in); #1;
      if (tx_done === 1'b1) done_count++;
    end
  end

  // Line decoder: on a low sample, collects 10 bits of 4 samples each,
  // flags any bit not stable for its whole period, decodes on sample 1.
  initial begin
    logic [9:0] bits;
    logic       s0, s1, s2, s3;
    forever begin
      @(posedge clk_in); #1;
      if (tx_serial_out === 1'b0) begin
        for (int b = 0; b < 10; b++) begin
          if (b != 0) begin @(posedge clk_in); #1; end
          s0 = tx_serial_out;
          @(posedge clk_in); #1; s1 = tx_serial_out;
          @(posedge clk_in); #1; s2 = tx_serial_out;
          @(posedge clk_in); #1; s3 = tx_serial_out;
          if (s0 !== s1 || s1 !== s2 || s2 !== s3) dec_bad_period++;
          bits[b] = s1;
        end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) dec_bad_frame++;
        dec_q.push_back(bits[8:1]);
      end
    end
  end

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  task automatic clear_scoreboard();
    exp_q.delete();
    dec_q.delete();
    dec_bad_period = 0;
    dec_bad_frame  = 0;
  endtask

  // Waits (bounded) for ready, performs one handshake, then scrambles the
  // data input. Returns at the cycle-1 sample of the new frame.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    while (uart_tx_ready !== 1'b1 && waited < 200) begin
      step();
      waited++;
    end
    if (uart_tx_ready !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL send_ready_timeout: ready=%b after %0d cycles, required 1", uart_tx_ready, waited);
    end
    uart_tx_en      = 1'b1;
    uart_tx_data_in = b;
    step();
    uart_tx_en      = 1'b0;
    uart_tx_data_in = 8'($urandom);
    exp_q.push_back(b);
  endtask

  task automatic test_reset();
    n_rst = 1'b0; uart_tx_en = 1'b0; uart_tx_data_in = 8'h00;
    repeat (3) step();
    tests_run++; if (uart_tx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b required 1", uart_tx_ready); end
    tests_run++; if (tx_serial_out !== 1'b1) begin tests_failed++; $display("FAIL reset_line: got %b required 1", tx_serial_out); end
    tests_run++; if (tx_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b required 0", tx_done); end
    n_rst = 1'b1;
    step();
    tests_run++; if (uart_tx_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_ready: got %b required 1", uart_tx_ready); end
    tests_run++; if (tx_serial_out !== 1'b1) begin tests_failed++; $display("FAIL post_reset_line: got %b required 1", tx_serial_out); end
    // First edge with en=1 after release must be a handshake.
    uart_tx_en = 1'b1; uart_tx_data_in = 8'h0F;
    step();
    uart_tx_en = 1'b0;
    tests_run++; if (uart_tx_ready !== 1'b0) begin tests_failed++; $display("FAIL first_hs_ready: got %b required 0", uart_tx_ready); end
    tests_run++; if (tx_serial_out !== 1'b0) begin tests_failed++; $display("FAIL first_hs_line: got %b required 0", tx_serial_out); end
    repeat (FRAME + 5) step();
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_frame();
    logic [9:0] fr;
    int d0;
    clear_scoreboard();
    d0 = done_count;
    fr = {1'b1, 8'h77, 1'b0};
    send_byte(8'h77);
    for (int k = 1; k <= FRAME; k++) begin
      tests_run++; if (tx_serial_out !== fr[(k-1)/CPB]) begin tests_failed++; $display("FAIL frame77_line cycle %0d: got %b required %b", k, tx_serial_out, fr[(k-1)/CPB]); end
      tests_run++; if (uart_tx_ready !== 1'b0) begin tests_failed++; $display("FAIL frame77_ready cycle %0d: got %b required 0", k, uart_tx_ready); end
      tests_run++; if (tx_done !== 1'b0) begin tests_failed++; $display("FAIL frame77_done cycle %0d: got %b required 0", k, tx_done); end
      step();
    end
    tests_run++; if (tx_done !== 1'b1) begin tests_failed++; $display("FAIL frame77_done_c41: got %b required 1", tx_done); end
    tests_run++; if (uart_tx_ready !== 1'b1) begin tests_failed++; $display("FAIL frame77_ready_c41: got %b required 1", uart_tx_ready); end
    tests_run++; if (tx_serial_out !== 1'b1) begin tests_failed++; $display("FAIL frame77_line_c41: got %b required 1", tx_serial_out); end
    step();
    tests_run++; if (tx_done !== 1'b0) begin tests_failed++; $display("FAIL frame77_done_c42: got %b required 0", tx_done); end
    step();
    tests_run++; if (done_count - d0 !== 1) begin tests_failed++; $display("FAIL frame77_done_count: got %0d required 1", done_count - d0); end
    tests_run++; if (dec_q.size() !== 1) begin tests_failed++; $display("FAIL frame77_dec_size: got %0d required 1", dec_q.size()); end
    else begin
      tests_run++; if (dec_q[0] !== 8'h77) begin tests_failed++; $display("FAIL frame77_dec: got %h required 77", dec_q[0]); end
    end
    $display("[TB] test_single_frame done");
  endtask

  task automatic test_zero_one();
    logic [7:0] vals[2];
    int         exp_lead[2];
    logic       s[FRAME];
    int         lead, tail, idx;
    vals[0] = 8'h00; exp_lead[0] = 36;
    vals[1] = 8'hFF; exp_lead[1] = 4;
    for (int v = 0; v < 2; v++) begin
      clear_scoreboard();
      send_byte(vals[v]);
      for (int k = 0; k < FRAME; k++) begin
        s[k] = tx_serial_out;
        step();
      end
      lead = 0;
      while (lead < FRAME && s[lead] === 1'b0) lead++;
      tail = 0; idx = lead;
      while (idx < FRAME && s[idx] === 1'b1) begin tail++; idx++; end
      tests_run++; if (lead !== exp_lead[v]) begin tests_failed++; $display("FAIL runlen_low byte %h: got %0d required %0d", vals[v], lead, exp_lead[v]); end
      tests_run++; if (tail !== FRAME - exp_lead[v]) begin tests_failed++; $display("FAIL runlen_high byte %h: got %0d required %0d", vals[v], tail, FRAME - exp_lead[v]); end
      tests_run++; if (tx_done !== 1'b1) begin tests_failed++; $display("FAIL runlen_done byte %h: got %b required 1", vals[v], tx_done); end
      repeat (2) step();
      tests_run++; if (dec_q.size() !== 1) begin tests_failed++; $display("FAIL runlen_dec_size byte %h: got %0d required 1", vals[v], dec_q.size()); end
      else begin
        tests_run++; if (dec_q[0] !== vals[v]) begin tests_failed++; $display("FAIL runlen_dec: got %h required %h", dec_q[0], vals[v]); end
      end
    end
    $display("[TB] test_zero_one done");
  endtask

  task automatic test_back_to_back();
    logic [9:0] fr1, fr2;
    clear_scoreboard();
    fr1 = {1'b1, 8'h72, 1'b0};
    fr2 = {1'b1, 8'h55, 1'b0};
    send_byte(8'h72);
    uart_tx_en = 1'b1; uart_tx_data_in = 8'h55;
    for (int k = 1; k <= FRAME; k++) begin
      tests_run++; if (tx_serial_out !== fr1[(k-1)/CPB]) begin tests_failed++; $display("FAIL b2b_72_line cycle %0d: got %b required %b", k, tx_serial_out, fr1[(k-1)/CPB]); end
      step();
    end
    // Cycle 41: exactly one idle-high cycle, ready high, done pulse.
    tests_run++; if (tx_serial_out !== 1'b1) begin tests_failed++; $display("FAIL b2b_gap_line: got %b required 1", tx_serial_out); end
    tests_run++; if (uart_tx_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_gap_ready: got %b required 1", uart_tx_ready); end
    tests_run++; if (tx_done !== 1'b1) begin tests_failed++; $display("FAIL b2b_gap_done: got %b required 1", tx_done); end
    step();
    uart_tx_en = 1'b0; uart_tx_data_in = 8'hAA;
    exp_q.push_back(8'h55);
    tests_run++; if (uart_tx_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_second_ready: got %b required 0", uart_tx_ready); end
    for (int k = 1; k <= FRAME; k++) begin
      tests_run++; if (tx_serial_out !== fr2[(k-1)/CPB]) begin tests_failed++; $display("FAIL b2b_55_line cycle %0d: got %b required %b", k, tx_serial_out, fr2[(k-1)/CPB]); end
      step();
    end
    tests_run++; if (tx_done !== 1'b1) begin tests_failed++; $display("FAIL b2b_55_done: got %b required 1", tx_done); end
    repeat (2) step();
    tests_run++; if (dec_q.size() !== 2) begin tests_failed++; $display("FAIL b2b_dec_size: got %0d required 2", dec_q.size()); end
    else begin
      tests_run++; if (dec_q[0] !== 8'h72) begin tests_failed++; $display("FAIL b2b_dec0: got %h required 72", dec_q[0]); end
      tests_run++; if (dec_q[1] !== 8'h55) begin tests_failed++; $display("FAIL b2b_dec1: got %h required 55", dec_q[1]); end
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_ignore_en();
    logic [9:0] fr;
    int d0;
    clear_scoreboard();
    d0 = done_count;
    fr = {1'b1, 8'hC3, 1'b0};
    send_byte(8'hC3);
    for (int k = 1; k <= FRAME; k++) begin
      tests_run++; if (tx_serial_out !== fr[(k-1)/CPB]) begin tests_failed++; $display("FAIL ignore_line cycle %0d: got %b required %b", k, tx_serial_out, fr[(k-1)/CPB]); end
      if (k == 38) begin uart_tx_en = 1'b1; uart_tx_data_in = 8'h99; end
      if (k == 39) uart_tx_en = 1'b0;
      step();
    end
    tests_run++; if (tx_done !== 1'b1) begin tests_failed++; $display("FAIL ignore_done: got %b required 1", tx_done); end
    for (int k = 0; k < 20; k++) begin
      tests_run++; if (tx_serial_out !== 1'b1) begin tests_failed++; $display("FAIL ignore_idle_line cycle %0d: got %b required 1", k, tx_serial_out); end
      tests_run++; if (uart_tx_ready !== 1'b1) begin tests_failed++; $display("FAIL ignore_idle_ready cycle %0d: got %b required 1", k, uart_tx_ready); end
      step();
    end
    tests_run++; if (done_count - d0 !== 1) begin tests_failed++; $display("FAIL ignore_done_count: got %0d required 1", done_count - d0); end
    tests_run++; if (dec_q.size() !== 1) begin tests_failed++; $display("FAIL ignore_dec_size: got %0d required 1", dec_q.size()); end
    $display("[TB] test_ignore_en done");
  endtask

  task automatic test_reset_midframe();
    logic [9:0] fr;
    int d0;
    clear_scoreboard();
    d0 = done_count;
    send_byte(8'hA5);
    for (int k = 1; k < 18; k++) step();
    // Cycle 18 lies inside data bit 3 (cycles 17..20).
    n_rst = 1'b0;
    #1;
    tests_run++; if (tx_serial_out !== 1'b1) begin tests_failed++; $display("FAIL midrst_line: got %b required 1", tx_serial_out); end
    tests_run++; if (uart_tx_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_ready: got %b required 1", uart_tx_ready); end
    tests_run++; if (tx_done !== 1'b0) begin tests_failed++; $display("FAIL midrst_done: got %b required 0", tx_done); end
    step();
    n_rst = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tests_run++; if (tx_serial_out !== 1'b1) begin tests_failed++; $display("FAIL midrst_idle_line cycle %0d: got %b required 1", k, tx_serial_out); end
      tests_run++; if (tx_done !== 1'b0) begin tests_failed++; $display("FAIL midrst_idle_done cycle %0d: got %b required 0", k, tx_done); end
      step();
    end
    tests_run++; if (done_count - d0 !== 0) begin tests_failed++; $display("FAIL midrst_done_count: got %0d required 0", done_count - d0); end
    clear_scoreboard();
    fr = {1'b1, 8'h3C, 1'b0};
    send_byte(8'h3C);
    for (int k = 1; k <= FRAME; k++) begin
      tests_run++; if (tx_serial_out !== fr[(k-1)/CPB]) begin tests_failed++; $display("FAIL midrst_3c_line cycle %0d: got %b required %b", k, tx_serial_out, fr[(k-1)/CPB]); end
      step();
    end
    tests_run++; if (tx_done !== 1'b1) begin tests_failed++; $display("FAIL midrst_3c_done: got %b required 1", tx_done); end
    repeat (2) step();
    tests_run++; if (dec_q.size() !== 1) begin tests_failed++; $display("FAIL midrst_dec_size: got %0d required 1", dec_q.size()); end
    else begin
      tests_run++; if (dec_q[0] !== 8'h3C) begin tests_failed++; $display("FAIL midrst_dec: got %h required 3c", dec_q[0]); end
    end
    $display("[TB] test_reset_midframe done");
  endtask

  task automatic test_random();
    int d0, n;
    clear_scoreboard();
    d0 = done_count;
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 5)) step();
      send_byte(8'($urandom));
    end
    repeat (FRAME + 10) step();
    tests_run++; if (dec_q.size() !== 256) begin tests_failed++; $display("FAIL rand_dec_size: got %0d required 256", dec_q.size()); end
    n = (dec_q.size() < exp_q.size()) ? dec_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      tests_run++; if (dec_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL rand_byte %0d: got %h required %h", i, dec_q[i], exp_q[i]); end
    end
    tests_run++; if (dec_bad_period !== 0) begin tests_failed++; $display("FAIL rand_bit_period: got %0d unstable bits required 0", dec_bad_period); end
    tests_run++; if (dec_bad_frame !== 0) begin tests_failed++; $display("FAIL rand_framing: got %0d bad frames required 0", dec_bad_frame); end
    tests_run++; if (done_count - d0 !== 256) begin tests_failed++; $display("FAIL rand_done_count: got %0d required 256", done_count - d0); end
    $display("[TB] test_random done");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_zero_one();
    test_back_to_back();
    test_ignore_en();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    tests_failed++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

endmodule
